// File: rtl/offchip_mem_pkg.sv
// Shared types and helpers for the off-chip memory slave and its channel controllers.
package offchip_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } chan_state_t;

  // Bit mask with the low 'size' bits set, saturating at 32 bits; callers keep the low DATA_W bits.
  function automatic logic [31:0] size_to_mask(input logic [7:0] size);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(size)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // True when addr falls in [base, base+memsize); the sum is formed one bit wider so it cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] memsize);
    logic [32:0] limit;
    limit = {1'b0, base} + {1'b0, memsize};
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/offchip_mem_chan_ctrl.sv
// Per-channel access sequencer: latency counter, captured read word / write payload,
// and the DataRdy / write-port decode for one memory channel.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no access in flight; a hit is accepted here
// RD_WAIT | read word captured, counting up to the read terminal count
// WR_WAIT | write payload captured, counting up to the write terminal count
module offchip_mem_chan_ctrl #(
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 7,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              oe,
  input  logic              we,
  input  logic              hit,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] mem_word,
  output logic              data_rdy,
  output logic [DATA_W-1:0] rdata,
  output logic              conflict,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] wr_mask
);
  import offchip_mem_pkg::*;

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT < 3) ? 1 : $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] RD_TC   = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_TC   = CNT_W'(WRITE_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chan_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              rd_req, wr_req;

  // oe and we together is a protocol error: it is flagged and never treated as a request.
  assign conflict = oe & we;
  assign rd_req   = oe & ~we;
  assign wr_req   = we & ~oe;

  // State, counter and captured payload registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state, completion strobe and write-port decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    data_rdy = 1'b0;
    rdata    = '0;
    wr_en    = 1'b0;
    wr_idx   = idx_q;
    wr_data  = wdata_q;
    wr_mask  = mask_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hit && rd_req) begin
          if (READ_LAT == 1) begin
            data_rdy = 1'b1;
            rdata    = mem_word;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_ONE;
            word_d  = mem_word;
          end
        end else if (hit && wr_req) begin
          if (WRITE_LAT == 1) begin
            data_rdy = 1'b1;
            wr_en    = 1'b1;
            wr_idx   = idx;
            wr_data  = wdata;
            wr_mask  = mask;
          end else begin
            state_d = WR_WAIT;
            cnt_d   = CNT_ONE;
            idx_d   = idx;
            wdata_d = wdata;
            mask_d  = mask;
          end
        end
      end

      RD_WAIT: begin
        if (!rd_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RD_TC) begin
          data_rdy = 1'b1;
          rdata    = word_q;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WR_WAIT: begin
        if (!wr_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WR_TC) begin
          data_rdy = 1'b1;
          wr_en    = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/offchip_mem_slave.sv
// Synthesizable off-chip memory serving the core's master memory bus. One shared word
// array, CHANNELS independent byte-lane channels, byte-masked writes merged in channel order.
module offchip_mem_slave #(
  parameter int CHANNELS  = 2,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int BASE_ADDR = 0,
  parameter int MEMSIZE   = 128,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          Mout_oe_ram,
  input  logic [CHANNELS-1:0]          Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
  output logic [CHANNELS-1:0]          M_DataRdy,
  output logic                         err_conflict
);
  import offchip_mem_pkg::*;

  localparam int IDX_W = (MEMSIZE < 2) ? 1 : $clog2(MEMSIZE);

  logic [DATA_W-1:0] mem [MEMSIZE];

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] conflict;
  logic [CHANNELS-1:0] wr_en;
  logic [IDX_W-1:0]    idx      [CHANNELS];
  logic [DATA_W-1:0]   mask     [CHANNELS];
  logic [DATA_W-1:0]   mem_word [CHANNELS];
  logic [IDX_W-1:0]    wr_idx   [CHANNELS];
  logic [DATA_W-1:0]   wr_data  [CHANNELS];
  logic [DATA_W-1:0]   wr_mask  [CHANNELS];
  logic [DATA_W-1:0]   merged   [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [31:0] addr_ext;
    logic [31:0] offset;
    logic [31:0] mask_full;
    logic        unused_hi;

    assign addr_ext     = 32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]);
    assign hit[c]       = in_window(addr_ext, 32'(BASE_ADDR), 32'(MEMSIZE));
    assign offset       = addr_ext - 32'(BASE_ADDR);
    assign idx[c]       = offset[IDX_W-1:0];
    assign mask_full    = size_to_mask(8'(Mout_data_ram_size[c*SIZE_W +: SIZE_W]));
    assign mask[c]      = mask_full[DATA_W-1:0];
    // Misses may index past the array; the controller ignores mem_word unless hit is set.
    assign mem_word[c]  = mem[idx[c]];
    assign unused_hi    = ^{offset[31:IDX_W], mask_full[31:DATA_W]};

    offchip_mem_chan_ctrl #(
      .DATA_W    (DATA_W),
      .IDX_W     (IDX_W),
      .READ_LAT  (READ_LAT),
      .WRITE_LAT (WRITE_LAT)
    ) u_ctrl (
      .clock    (clock),
      .reset    (reset),
      .oe       (Mout_oe_ram[c]),
      .we       (Mout_we_ram[c]),
      .hit      (hit[c]),
      .idx      (idx[c]),
      .wdata    (Mout_Wdata_ram[c*DATA_W +: DATA_W]),
      .mask     (mask[c]),
      .mem_word (mem_word[c]),
      .data_rdy (M_DataRdy[c]),
      .rdata    (M_Rdata_ram[c*DATA_W +: DATA_W]),
      .conflict (conflict[c]),
      .wr_en    (wr_en[c]),
      .wr_idx   (wr_idx[c]),
      .wr_data  (wr_data[c]),
      .wr_mask  (wr_mask[c])
    );
  end

  // Each write port's final word folds in every same-edge write to that word, lowest channel
  // first, so overlapping bits go to the highest channel and disjoint bits all survive.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      merged[c] = mem[wr_idx[c]];
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_en[k] && (wr_idx[k] == wr_idx[c])) begin
          merged[c] = (wr_data[k] & wr_mask[k]) | (merged[c] & ~wr_mask[k]);
        end
      end
    end
  end

  // Storage write ports; contents are deliberately left untouched by reset.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_en[c]) mem[wr_idx[c]] <= merged[c];
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_conflict <= 1'b0;
    end else if (|conflict) begin
      err_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_offchip_mem_slave.sv
// Directed bench: dut_a uses the default latencies (read 2, write 1) and runs a vector table
// plus conflict/reset sequences; dut_b uses read 3 / write 3 for abort and reset-mid-write cases.
module tb_offchip_mem_slave;

  logic        clock;
  logic        reset_a, reset_b;
  logic [1:0]  oe_a, we_a, rdy_a;
  logic [17:0] addr_a;
  logic [15:0] wd_a, rd_a;
  logic [7:0]  sz_a;
  logic        err_a;
  logic [1:0]  oe_b, we_b, rdy_b;
  logic [17:0] addr_b;
  logic [15:0] wd_b, rd_b;
  logic [7:0]  sz_b;
  logic        err_b;

  int total = 0;
  int bad   = 0;

  offchip_mem_slave dut_a (
    .clock              (clock),
    .reset              (reset_a),
    .Mout_oe_ram        (oe_a),
    .Mout_we_ram        (we_a),
    .Mout_addr_ram      (addr_a),
    .Mout_Wdata_ram     (wd_a),
    .Mout_data_ram_size (sz_a),
    .M_Rdata_ram        (rd_a),
    .M_DataRdy          (rdy_a),
    .err_conflict       (err_a)
  );

  offchip_mem_slave #(.READ_LAT(3), .WRITE_LAT(3)) dut_b (
    .clock              (clock),
    .reset              (reset_b),
    .Mout_oe_ram        (oe_b),
    .Mout_we_ram        (we_b),
    .Mout_addr_ram      (addr_b),
    .Mout_Wdata_ram     (wd_b),
    .Mout_data_ram_size (sz_b),
    .M_Rdata_ram        (rd_b),
    .M_DataRdy          (rdy_b),
    .err_conflict       (err_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] oe, we;
    logic [8:0] a0, a1;
    logic [7:0] d0, d1;
    logic [3:0] s0, s1;
    logic [1:0] rdy;
    logic [7:0] r0, r1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] oe, input logic [1:0] we,
                     input logic [8:0] a0, input logic [7:0] d0, input logic [3:0] s0,
                     input logic [8:0] a1, input logic [7:0] d1, input logic [3:0] s1,
                     input logic [1:0] rdy, input logic [7:0] r0, input logic [7:0] r1);
    vec_t v;
    v.oe = oe; v.we = we; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.a1 = a1; v.d1 = d1; v.s1 = s1; v.rdy = rdy; v.r0 = r0; v.r1 = r1;
    vecs.push_back(v);
  endtask

  task automatic idle_vec();
    add(2'b00, 2'b00, 9'd0, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
  endtask

  // One dut_b cycle on channel 0: drive after the edge, check at the falling edge.
  task automatic b_cycle(input string nm, input logic oe, input logic we, input logic [8:0] a,
                         input logic [7:0] d, input logic [1:0] exp_rdy, input logic [7:0] exp_r0);
    @(posedge clock); #1;
    oe_b = {1'b0, oe}; we_b = {1'b0, we}; addr_b = {9'd0, a}; wd_b = {8'h00, d}; sz_b = 8'h08;
    @(negedge clock);
    check({nm, ".rdy"}, 32'(rdy_b), 32'(exp_rdy));
    check({nm, ".rdata"}, 32'(rd_b), {16'h0, 8'h00, exp_r0});
  endtask

  initial begin
    clock = 1'b0;
    reset_a = 1'b0; reset_b = 1'b0;
    oe_a = '0; we_a = '0; addr_a = '0; wd_a = '0; sz_a = '0;
    oe_b = '0; we_b = '0; addr_b = '0; wd_b = '0; sz_b = '0;

    #12;
    check("reset_a.rdy",   32'(rdy_a), 32'h0);
    check("reset_a.rdata", 32'(rd_a),  32'h0);
    check("reset_a.err",   32'(err_a), 32'h0);
    check("reset_b.rdy",   32'(rdy_b), 32'h0);
    check("reset_b.rdata", 32'(rd_b),  32'h0);
    @(negedge clock);
    reset_a = 1'b1; reset_b = 1'b1;

    // oe, we, a0, d0, s0, a1, d1, s1, rdy, r0, r1
    add(2'b00, 2'b01, 9'd5, 8'hA5, 4'd8, 9'd0, 8'h00, 4'd0, 2'b01, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd5, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd5, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b01, 8'hA5, 8'h00);
    idle_vec();
    add(2'b00, 2'b01, 9'd3, 8'hFF, 4'd8, 9'd0, 8'h00, 4'd0, 2'b01, 8'h00, 8'h00);
    add(2'b00, 2'b01, 9'd3, 8'h00, 4'd4, 9'd0, 8'h00, 4'd0, 2'b01, 8'h00, 8'h00);
    add(2'b10, 2'b00, 9'd0, 8'h00, 4'd0, 9'd3, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    add(2'b10, 2'b00, 9'd0, 8'h00, 4'd0, 9'd3, 8'h00, 4'd0, 2'b10, 8'h00, 8'hF0);
    idle_vec();
    add(2'b00, 2'b11, 9'd7, 8'h11, 4'd8, 9'd7, 8'h22, 4'd8, 2'b11, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd7, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd7, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b01, 8'h22, 8'h00);
    idle_vec();
    add(2'b00, 2'b10, 9'd0, 8'h00, 4'd0, 9'd9, 8'h5A, 4'd8, 2'b10, 8'h00, 8'h00);
    add(2'b01, 2'b10, 9'd9, 8'h00, 4'd0, 9'd9, 8'hC3, 4'd8, 2'b10, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd9, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b01, 8'h5A, 8'h00);
    add(2'b01, 2'b00, 9'd9, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd9, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b01, 8'hC3, 8'h00);
    idle_vec();
    for (int i = 0; i < 4; i++)
      add(2'b01, 2'b00, 9'd200, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    idle_vec();
    add(2'b00, 2'b01, 9'd72, 8'h66, 4'd8, 9'd0, 8'h00, 4'd0, 2'b01, 8'h00, 8'h00);
    add(2'b00, 2'b10, 9'd0, 8'h00, 4'd0, 9'd200, 8'h00, 4'd8, 2'b00, 8'h00, 8'h00);
    add(2'b10, 2'b00, 9'd0, 8'h00, 4'd0, 9'd72, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    add(2'b10, 2'b00, 9'd0, 8'h00, 4'd0, 9'd72, 8'h00, 4'd0, 2'b10, 8'h00, 8'h66);
    idle_vec();
    add(2'b00, 2'b01, 9'd3, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b01, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd3, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd3, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b01, 8'hF0, 8'h00);
    idle_vec();
    add(2'b00, 2'b01, 9'd3, 8'h3C, 4'd15, 9'd0, 8'h00, 4'd0, 2'b01, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd3, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    add(2'b01, 2'b00, 9'd3, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b01, 8'h3C, 8'h00);
    idle_vec();
    add(2'b00, 2'b01, 9'd0, 8'h81, 4'd8, 9'd0, 8'h00, 4'd0, 2'b01, 8'h00, 8'h00);
    add(2'b00, 2'b01, 9'd127, 8'h7E, 4'd8, 9'd0, 8'h00, 4'd0, 2'b01, 8'h00, 8'h00);
    add(2'b00, 2'b10, 9'd0, 8'h00, 4'd0, 9'd128, 8'h00, 4'd8, 2'b00, 8'h00, 8'h00);
    add(2'b11, 2'b00, 9'd127, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b00, 8'h00, 8'h00);
    add(2'b11, 2'b00, 9'd127, 8'h00, 4'd0, 9'd0, 8'h00, 4'd0, 2'b11, 8'h7E, 8'h81);
    idle_vec();

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock); #1;
      oe_a = vecs[i].oe; we_a = vecs[i].we;
      addr_a = {vecs[i].a1, vecs[i].a0};
      wd_a   = {vecs[i].d1, vecs[i].d0};
      sz_a   = {vecs[i].s1, vecs[i].s0};
      @(negedge clock);
      check($sformatf("v%0d.rdy", i),   32'(rdy_a), 32'(vecs[i].rdy));
      check($sformatf("v%0d.rdata", i), 32'(rd_a),  32'({vecs[i].r1, vecs[i].r0}));
      check($sformatf("v%0d.err", i),   32'(err_a), 32'h0);
    end

    // Conflict on channel 1: flag appears the next cycle, sticks, clears only on reset.
    @(posedge clock); #1;
    oe_a = 2'b10; we_a = 2'b10; addr_a = {9'd4, 9'd0}; wd_a = 16'h5500; sz_a = 8'h80;
    @(negedge clock);
    check("conflict.rdy", 32'(rdy_a), 32'h0);
    check("conflict.err_same_cycle", 32'(err_a), 32'h0);
    @(posedge clock); #1;
    oe_a = '0; we_a = '0; addr_a = '0; wd_a = '0; sz_a = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("conflict.err_sticky%0d", i), 32'(err_a), 32'h1);
      check($sformatf("conflict.rdy_after%0d", i), 32'(rdy_a), 32'h0);
      @(posedge clock); #1;
    end
    reset_a = 1'b0;
    #1;
    check("conflict.err_reset", 32'(err_a), 32'h0);
    @(negedge clock);
    reset_a = 1'b1;

    // Storage survives reset.
    @(posedge clock); #1;
    oe_a = 2'b01; addr_a = {9'd0, 9'd5};
    @(negedge clock);
    check("survive.rdy0", 32'(rdy_a), 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    check("survive.rdy1", 32'(rdy_a), 32'h1);
    check("survive.rdata", 32'(rd_a), 32'h00A5);
    @(posedge clock); #1;
    oe_a = '0; addr_a = '0;

    // dut_b: write latency 3, read latency 3.
    b_cycle("b_wr0", 1'b0, 1'b1, 9'd10, 8'h3C, 2'b00, 8'h00);
    b_cycle("b_wr1", 1'b0, 1'b1, 9'd10, 8'h3C, 2'b00, 8'h00);
    b_cycle("b_wr2", 1'b0, 1'b1, 9'd10, 8'h3C, 2'b01, 8'h00);
    b_cycle("b_idle0", 1'b0, 1'b0, 9'd0, 8'h00, 2'b00, 8'h00);
    b_cycle("b_rd0", 1'b1, 1'b0, 9'd10, 8'h00, 2'b00, 8'h00);
    b_cycle("b_rd1", 1'b1, 1'b0, 9'd10, 8'h00, 2'b00, 8'h00);
    b_cycle("b_rd2", 1'b1, 1'b0, 9'd10, 8'h00, 2'b01, 8'h3C);
    b_cycle("b_idle1", 1'b0, 1'b0, 9'd0, 8'h00, 2'b00, 8'h00);
    // Read abort: oe only for the accept cycle.
    b_cycle("b_rab0", 1'b1, 1'b0, 9'd10, 8'h00, 2'b00, 8'h00);
    b_cycle("b_rab1", 1'b0, 1'b0, 9'd10, 8'h00, 2'b00, 8'h00);
    b_cycle("b_rab2", 1'b0, 1'b0, 9'd10, 8'h00, 2'b00, 8'h00);
    b_cycle("b_rab3", 1'b0, 1'b0, 9'd10, 8'h00, 2'b00, 8'h00);
    // Write abort: we dropped in WR_WAIT, pending data discarded.
    b_cycle("b_wab0", 1'b0, 1'b1, 9'd10, 8'h77, 2'b00, 8'h00);
    b_cycle("b_wab1", 1'b0, 1'b0, 9'd10, 8'h77, 2'b00, 8'h00);
    b_cycle("b_wab2", 1'b0, 1'b0, 9'd10, 8'h77, 2'b00, 8'h00);
    // Reset in the DataRdy cycle of a write: outputs drop at once and nothing commits.
    b_cycle("b_wrs0", 1'b0, 1'b1, 9'd10, 8'h99, 2'b00, 8'h00);
    b_cycle("b_wrs1", 1'b0, 1'b1, 9'd10, 8'h99, 2'b00, 8'h00);
    b_cycle("b_wrs2", 1'b0, 1'b1, 9'd10, 8'h99, 2'b01, 8'h00);
    #1;
    reset_b = 1'b0;
    #1;
    check("b_wrs.rdy_in_reset", 32'(rdy_b), 32'h0);
    check("b_wrs.rdata_in_reset", 32'(rd_b), 32'h0);
    @(posedge clock); #1;
    oe_b = '0; we_b = '0; addr_b = '0; wd_b = '0;
    @(negedge clock);
    check("b_wrs.rdy_held_reset", 32'(rdy_b), 32'h0);
    reset_b = 1'b1;
    b_cycle("b_chk0", 1'b1, 1'b0, 9'd10, 8'h00, 2'b00, 8'h00);
    b_cycle("b_chk1", 1'b1, 1'b0, 9'd10, 8'h00, 2'b00, 8'h00);
    b_cycle("b_chk2", 1'b1, 1'b0, 9'd10, 8'h00, 2'b01, 8'h3C);
    b_cycle("b_idle2", 1'b0, 1'b0, 9'd0, 8'h00, 2'b00, 8'h00);
    check("b_err", 32'(err_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/offchip_mem_slave.md
# offchip_mem_slave

Synthesizable off-chip memory model serving the HLS `main` core's master memory bus (`Mout_*` → `M_Rdata_ram`/`M_DataRdy`). It replaces the behavioural, testbench-embedded memory so the same core plus memory can run in emulation and on the Zynq fabric. It has CHANNELS independent byte-lane channels with configurable read and write latency, and byte-masked partial writes. It sits directly downstream of the core's memory master port; its outputs are OR-ed with the core's `Sout_*` slave responses by the integrating top.

## Interface
- CHANNELS, 2, number of independent memory channels.
- ADDR_W, 9, address bits per channel.
- DATA_W, 8, data bits per channel.
- SIZE_W, 4, access-size field per channel; it carries the number of valid bits (0..DATA_W).
- BASE_ADDR, 0, first byte address owned by this slave.
- MEMSIZE, 128, number of DATA_W-wide words; the window is [BASE_ADDR, BASE_ADDR+MEMSIZE).
- READ_LAT, 2, cycles from read accept to data (≥1).
- WRITE_LAT, 1, cycles from write accept to DataRdy (≥1).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- Mout_oe_ram  in  CHANNELS  per-channel read request, held until DataRdy.
- Mout_we_ram  in  CHANNELS  per-channel write request, held until DataRdy.
- Mout_addr_ram  in  CHANNELS*ADDR_W  channel c address is at [c*ADDR_W +: ADDR_W].
- Mout_Wdata_ram  in  CHANNELS*DATA_W  write data.
- Mout_data_ram_size  in  CHANNELS*SIZE_W  access size in bits.
- M_Rdata_ram  out  CHANNELS*DATA_W  read data; 0 when not responding.
- M_DataRdy  out  CHANNELS  per-channel completion strobe.
- err_conflict  out  1  sticky; set when a channel drives oe and we together.

## Operation
- Hit for channel c: BASE_ADDR ≤ addr_c < BASE_ADDR+MEMSIZE. Word index = addr_c − BASE_ADDR.
- A miss gets no response: DataRdy=0 and Rdata=0. Another slave then answers, and the per-bit OR stays valid.
- Mask = (1<<size)−1, truncated to DATA_W. Size=0 gives a no-op write; it still completes.
- Each channel runs its own FSM:
  - IDLE → RD_WAIT on a hit with oe=1. The word is captured at accept and the counter is set to 1.
  - IDLE → WR_WAIT on a hit with we=1 (WRITE_LAT>1). The address, data and mask are captured.
  - RD_WAIT: the counter increments each cycle. DataRdy=1 and Rdata=captured word in the cycle the counter equals READ_LAT−1 (combinational from state). The FSM then returns to IDLE.
  - WR_WAIT: same structure. The write commits to storage on the edge that ends the DataRdy cycle.
  - With WRITE_LAT=1: DataRdy is asserted combinationally in the same cycle as we on a hit, and the write commits on that edge with no state change.
  - Request deasserted in RD_WAIT/WR_WAIT → back to IDLE. No DataRdy is issued and a pending write is discarded.
  - A request held after DataRdy is treated as a new access on the following cycle.
- Write commit: mem = (wdata & mask) | (mem & ~mask).
- Two channels writing the same word on the same edge: each lane is merged in channel-index order, so for overlapping mask bits the higher index wins.
- A read captured on the same edge as a write commit to that word returns the old data.
- oe & we on one channel: err_conflict sets (sticky) and the request is ignored that cycle.
- Reset:
  - FSMs go to IDLE, counters to 0, M_DataRdy=0, M_Rdata_ram=0, err_conflict=0.
  - Storage is not reset and contents survive reset.
  - Reset mid-access aborts it, with no commit.

## Timing
- Read latency: DataRdy appears READ_LAT−1 cycles after the first oe cycle. With READ_LAT=2 that is 1 cycle, and 1 access per 2 cycles per channel.
- Write latency: DataRdy appears WRITE_LAT−1 cycles after the first we cycle. With WRITE_LAT=1 it is the same cycle.
- Channels are fully independent and can be busy concurrently.
- There are no combinational paths other than hit decode → DataRdy, and state → Rdata.

## Structure
- Shared package `offchip_mem_pkg`:
  - state enum {IDLE, RD_WAIT, WR_WAIT};
  - function `size_to_mask(size)`;
  - function `in_window(addr)`.
- Sub-module `offchip_mem_chan_ctrl`, instantiated CHANNELS times. It holds the FSM, latency counter, captured data/mask and the DataRdy decode.
- Storage is a single array in the top, with CHANNELS write ports applied in index order.

## Test plan
- Write then read, ch0: addr 5, data 8'hA5, size 8 → DataRdy same cycle. Read addr 5 → DataRdy one cycle after oe, with Rdata=8'hA5.
- Partial write: mem[3]=8'hFF, write 8'h00 with size 4 → read returns 8'hF0.
- Same-word collision: ch0 writes 8'h11 and ch1 writes 8'h22 to addr 7 on the same edge → read returns 8'h22. Separately, ch0 reads addr 9 while ch1 writes addr 9 on the capture edge → old value returned.
- Window miss (BASE_ADDR=0, MEMSIZE=128): read addr 200 held 4 cycles → DataRdy=0 and Rdata=0 throughout; storage unchanged.
- Abort and reset:
  - oe dropped after the first cycle (READ_LAT=3) → no DataRdy.
  - reset asserted during WR_WAIT (WRITE_LAT=3) → outputs 0 immediately, no commit; earlier contents are intact after reset.
- Conflict: ch1 drives oe=we=1 for one cycle → err_conflict=1 from the next cycle and stays high until reset; no DataRdy.
